// File: rtl/seg_mux_decoder.sv
// Receive side of a multiplexed 3-digit 7-segment display: synchronizes the segment and
// digit-enable lines, captures each digit once its pattern has settled, and rebuilds the
// displayed value as BCD and binary once the units digit closes a frame.
module seg_mux_decoder #(
    parameter int unsigned SETTLE  = 16,
    parameter int unsigned TIMEOUT = 2400000
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       en_units,
    input  logic       en_tens,
    input  logic       en_hundreds,
    output logic [9:0] value,
    output logic [3:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_units,
    output logic [2:0] blank_mask,
    output logic       valid,
    output logic       frame_err,
    output logic       stale
);

    localparam int unsigned SW = 10;
    localparam int unsigned CW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] sync1, sync2, prev;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;

    logic [2:0] seen;
    logic [3:0] dig_h, dig_t, dig_u;
    logic       ferr;
    logic       commit;

    logic [2:0] en_c;
    logic [6:0] seg_c;
    logic       stable_c, capture_c, multi_c;
    logic       dec_ok_c;
    logic [3:0] dec_digit_c;
    logic [3:0] h_c, t_c, u_c;
    logic [9:0] sum_c;

    assign en_c      = sync2[9:7];
    assign seg_c     = sync2[6:0];
    assign stable_c  = (sync2 == prev);
    assign capture_c = stable_c && (cnt == CW'(SETTLE - 2));
    assign multi_c   = (en_c & (en_c - 3'd1)) != 3'd0;

    // Two-flop synchronizer plus a one-cycle history copy for change detection
    always_ff @(posedge hwclk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {en_hundreds, en_tens, en_units, seg_in};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Settle counter: restarts on any change, parks at SETTLE-1 so each stable run captures once
    always_ff @(posedge hwclk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!stable_c) begin
            cnt <= '0;
        end else if (cnt != CW'(SETTLE - 1)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Segment pattern to digit; blank segments read as a seen zero
    always_comb begin
        dec_ok_c    = 1'b1;
        dec_digit_c = 4'd0;
        case (seg_c)
            7'h3F, 7'h00: dec_digit_c = 4'd0;
            7'h06:        dec_digit_c = 4'd1;
            7'h5B:        dec_digit_c = 4'd2;
            7'h4F:        dec_digit_c = 4'd3;
            7'h66:        dec_digit_c = 4'd4;
            7'h6D:        dec_digit_c = 4'd5;
            7'h7D:        dec_digit_c = 4'd6;
            7'h07:        dec_digit_c = 4'd7;
            7'h7F:        dec_digit_c = 4'd8;
            7'h6F:        dec_digit_c = 4'd9;
            default:      dec_ok_c    = 1'b0;
        endcase
    end

    // Frame assembly: store captured digits, flag errors, schedule a commit after units
    always_ff @(posedge hwclk) begin
        if (rst) begin
            seen   <= '0;
            ferr   <= 1'b0;
            commit <= 1'b0;
            dig_h  <= '0;
            dig_t  <= '0;
            dig_u  <= '0;
        end else begin
            commit <= 1'b0;
            if (commit) begin
                seen <= '0;
                ferr <= 1'b0;
            end
            if (capture_c && (en_c != 3'b000)) begin
                if (multi_c) begin
                    ferr <= 1'b1;
                end else begin
                    case (en_c)
                        3'b001: begin
                            seen[0] <= 1'b1;
                            dig_u   <= dec_digit_c;
                            commit  <= 1'b1;
                        end
                        3'b010: begin
                            seen[1] <= 1'b1;
                            dig_t   <= dec_digit_c;
                        end
                        default: begin
                            seen[2] <= 1'b1;
                            dig_h   <= dec_digit_c;
                        end
                    endcase
                    if (!dec_ok_c) begin
                        ferr <= 1'b1;
                    end
                end
            end
        end
    end

    // Frame digits with unseen slots forced to zero, and their binary value
    always_comb begin
        h_c   = seen[2] ? dig_h : 4'd0;
        t_c   = seen[1] ? dig_t : 4'd0;
        u_c   = seen[0] ? dig_u : 4'd0;
        sum_c = 10'(h_c) * 10'd100 + 10'(t_c) * 10'd10 + 10'(u_c);
    end

    // Output registers: update on a clean commit, pulse frame_err otherwise
    always_ff @(posedge hwclk) begin
        if (rst) begin
            value        <= '0;
            bcd_hundreds <= '0;
            bcd_tens     <= '0;
            bcd_units    <= '0;
            blank_mask   <= 3'b111;
            valid        <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (commit) begin
                if (ferr) begin
                    frame_err <= 1'b1;
                end else begin
                    value        <= sum_c;
                    bcd_hundreds <= h_c;
                    bcd_tens     <= t_c;
                    bcd_units    <= u_c;
                    blank_mask   <= ~seen;
                    valid        <= 1'b1;
                end
            end
        end
    end

    // Staleness timer: saturates at TIMEOUT; only a clean commit clears it
    always_ff @(posedge hwclk) begin
        if (rst) begin
            tcnt  <= '0;
            stale <= 1'b1;
        end else if (commit && !ferr) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else if (tcnt != TW'(TIMEOUT)) begin
            tcnt <= tcnt + TW'(1);
            if (tcnt == TW'(TIMEOUT - 1)) begin
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_mux_decoder.sv
// Randomized and directed bench for seg_mux_decoder against a frame-level reference model.
module tb_seg_mux_decoder;

    localparam int unsigned SETTLE  = 16;
    localparam int unsigned TIMEOUT = 600;

    logic       hwclk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       en_units, en_tens, en_hundreds;
    logic [9:0] value;
    logic [3:0] bcd_hundreds, bcd_tens, bcd_units;
    logic [2:0] blank_mask;
    logic       valid, frame_err, stale;

    seg_mux_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .hwclk(hwclk), .rst(rst), .seg_in(seg_in),
        .en_units(en_units), .en_tens(en_tens), .en_hundreds(en_hundreds),
        .value(value), .bcd_hundreds(bcd_hundreds), .bcd_tens(bcd_tens),
        .bcd_units(bcd_units), .blank_mask(blank_mask),
        .valid(valid), .frame_err(frame_err), .stale(stale)
    );

    always #5 hwclk = ~hwclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed pulse counts and cycles since the last clean commit
    int nv = 0;
    int ne = 0;
    int since = TIMEOUT;

    // Reference model state
    int m_seen [3];
    int m_dig  [3];
    int m_ferr;
    int x_value;
    int x_bcd  [3];
    int x_blank;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [6:0] s);
        if (s == 7'h00) return 0;
        for (int i = 0; i < 10; i++) if (seg_tab[i] == s) return i;
        return -1;
    endfunction

    function automatic logic [6:0] bad_pattern();
        logic [6:0] p;
        do p = 7'($urandom_range(1, 127)); while (decode(p) >= 0);
        return p;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin m_seen[i] = 0; m_dig[i] = 0; end
        m_ferr = 0;
    endtask

    // One falling edge: sample pulses, track staleness expectations
    task automatic tick();
        @(negedge hwclk);
        if (frame_err) ne++;
        if (valid) begin
            nv++;
            since = 0;
            check_eq("stale_clr_on_valid", int'(stale), 0);
        end else begin
            if (since < TIMEOUT) since++;
            if (since == TIMEOUT - 1) check_eq("stale_early", int'(stale), 0);
            else if (since == TIMEOUT) check_eq("stale_set", int'(stale), 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {en_hundreds, en_tens, en_units} = 3'b000;
        seg_in = 7'h00;
        tick();
        tick();
        check_eq("rst_value", int'(value), 0);
        check_eq("rst_blank", int'(blank_mask), 7);
        check_eq("rst_valid", int'(valid), 0);
        check_eq("rst_ferr", int'(frame_err), 0);
        check_eq("rst_stale", int'(stale), 1);
        rst = 1'b0;
        since = TIMEOUT;
        model_clear();
        x_value = 0; x_bcd = '{0, 0, 0}; x_blank = 7;
        repeat (4) tick();
    endtask

    // Drive one enable/segment pattern for hold cycles, then a blank gap; check the outcome
    task automatic drive_slot(input logic [2:0] en, input logic [6:0] seg, input int hold, input int gap);
        int v0 = nv;
        int e0 = ne;
        int lat = 0;
        int ones, idx, d;
        {en_hundreds, en_tens, en_units} = en;
        seg_in = seg;
        for (int i = 0; i < hold + gap; i++) begin
            if (i == hold) begin
                {en_hundreds, en_tens, en_units} = 3'b000;
                seg_in = 7'h00;
            end
            tick();
            if (lat == 0 && (valid || frame_err)) lat = i + 1;
        end
        ones = int'(en[0]) + int'(en[1]) + int'(en[2]);
        if (hold >= int'(SETTLE) && ones > 1) m_ferr = 1;
        if (hold >= int'(SETTLE) && ones == 1) begin
            idx = en[0] ? 0 : (en[1] ? 1 : 2);
            d = decode(seg);
            m_seen[idx] = 1;
            m_dig[idx] = (d < 0) ? 0 : d;
            if (d < 0) m_ferr = 1;
            if (idx == 0) begin
                if (m_ferr == 0) begin
                    for (int k = 0; k < 3; k++) x_bcd[k] = m_seen[k] ? m_dig[k] : 0;
                    x_value = 100 * x_bcd[2] + 10 * x_bcd[1] + x_bcd[0];
                    x_blank = (m_seen[2] ? 0 : 4) + (m_seen[1] ? 0 : 2) + (m_seen[0] ? 0 : 1);
                end
                check_eq("commit_latency", lat, int'(SETTLE) + 3);
                check_eq("valid_pulses", nv - v0, m_ferr ? 0 : 1);
                check_eq("ferr_pulses", ne - e0, m_ferr ? 1 : 0);
                check_eq("value", int'(value), x_value);
                check_eq("bcd_hundreds", int'(bcd_hundreds), x_bcd[2]);
                check_eq("bcd_tens", int'(bcd_tens), x_bcd[1]);
                check_eq("bcd_units", int'(bcd_units), x_bcd[0]);
                check_eq("blank_mask", int'(blank_mask), x_blank);
                model_clear();
                return;
            end
        end
        check_eq("no_commit", (nv - v0) + (ne - e0), 0);
    endtask

    task automatic digit(input logic [2:0] en, input int d);
        drive_slot(en, seg_tab[d], 64, 8);
    endtask

    task automatic random_slot(input logic [2:0] en);
        int kind = $urandom_range(0, 19);
        int hold = $urandom_range(SETTLE + 4, 64);
        int gap  = $urandom_range(4, 10);
        if ($urandom_range(0, 3) == 0)
            drive_slot(3'b001 << $urandom_range(0, 2), 7'($urandom_range(1, 127)),
                       $urandom_range(2, SETTLE - 2), $urandom_range(2, 6));
        if (kind == 0 && en != 3'b001) drive_slot(en | 3'b011, seg_tab[$urandom_range(0, 9)], hold, gap);
        else if (kind == 1) drive_slot(en, bad_pattern(), hold, gap);
        else if (kind == 2) drive_slot(en, 7'h00, hold, gap);
        else drive_slot(en, seg_tab[$urandom_range(0, 9)], hold, gap);
    endtask

    initial begin
        model_clear();
        do_reset();

        // Full frame 123
        digit(3'b100, 1); digit(3'b010, 2); digit(3'b001, 3);
        // Bad tens pattern: error, hold 123; then clean 567
        digit(3'b100, 9);
        drive_slot(3'b010, 7'h01, 64, 8);
        digit(3'b001, 0);
        check_eq("hold_after_err", int'(value), 123);
        digit(3'b100, 5); digit(3'b010, 6); digit(3'b001, 7);
        // Blank hundreds -> 42
        digit(3'b010, 4); digit(3'b001, 2);
        // Short tens glitch not captured -> 1, blank 110
        drive_slot(3'b010, 7'h5B, SETTLE - 2, 8);
        digit(3'b001, 1);
        // Two enables together, then units -> error, then clean frame
        drive_slot(3'b011, 7'h06, 64, 8);
        digit(3'b001, 4);
        digit(3'b100, 3); digit(3'b010, 0); digit(3'b001, 9);
        // Idle past the timeout, an error frame keeps stale, then a good frame clears it
        for (int i = 0; i < int'(TIMEOUT) + 20; i++) tick();
        check_eq("stale_idle", int'(stale), 1);
        drive_slot(3'b001, 7'h55, 64, 8);
        check_eq("stale_after_err", int'(stale), 1);
        digit(3'b010, 7); digit(3'b001, 7);
        // Reset mid-frame discards the hundreds digit
        digit(3'b100, 9);
        do_reset();
        digit(3'b010, 0); digit(3'b001, 8);
        check_eq("post_rst_value", int'(value), 8);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 3) != 0) random_slot(3'b100);
                if ($urandom_range(0, 3) != 0) random_slot(3'b010);
            end else begin
                if ($urandom_range(0, 3) != 0) random_slot(3'b010);
                if ($urandom_range(0, 3) != 0) random_slot(3'b100);
            end
            if ($urandom_range(0, 4) == 0) random_slot(3'b010);
            random_slot(3'b001);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
